// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM state encoding and constants for the fetch stage.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory req/ack handshake.
//   imem_req   - fetch request (master -> slave)
//   imem_addr  - fetch address (master -> slave)
//   imem_ack   - read data valid this cycle (slave -> master)
//   imem_rdata - fetched word (slave -> master)
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_next_pc.sv
// next_pc_calc: combinational next-PC selection for the retiring instruction.
//   pc          - address of the retiring instruction
//   instr       - low 26 bits of the retiring instruction (jump index / branch offset)
//   branch_en   - taken branch
//   jump_en     - j/jal
//   jump_reg_en - jr/jalr
//   rs_data     - register jump target
//   next_pc     - selected next PC (jr > j > branch > sequential)
//   misalign    - jr target has nonzero low bits
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic        branch_en,
    input  logic        jump_en,
    input  logic        jump_reg_en,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misalign
);
    logic [31:0] pc4;
    logic [31:0] br_off;

    always_comb begin
        pc4      = pc + 32'd4;
        br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc  = jump_reg_en ? {rs_data[31:2], 2'b00} :
                   jump_en     ? {pc4[31:28], instr, 2'b00} :
                   branch_en   ? pc4 + br_off : pc4;
        misalign = jump_reg_en & |rs_data[1:0];
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage; holds PC, fetches via req/ack, presents pc/instr to decode.
//   clk, rst                 - clock, synchronous active-high reset
//   stall                    - downstream hold; held instruction does not retire
//   branch_en/jump_en/jump_reg_en, rs_data - next-PC controls, sampled at retire
//   imem                     - instruction-memory handshake (master side)
//   pc, instr, instr_valid   - held instruction for decode
//   retire_count             - retired instruction count (wraps)
//   addr_err                 - sticky misaligned jr target
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_en,
    input  logic                jump_en,
    input  logic                jump_reg_en,
    input  logic [31:0]         rs_data,
    instr_fetch_if.master       imem,
    output logic [31:0]         pc,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         retire_count,
    output logic                addr_err
);
    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] next_pc;
    logic        misalign, retire, take;

    next_pc_calc u_next_pc (
        .pc          (pc_q),
        .instr       (instr_q[25:0]),
        .branch_en   (branch_en),
        .jump_en     (jump_en),
        .jump_reg_en (jump_reg_en),
        .rs_data     (rs_data),
        .next_pc     (next_pc),
        .misalign    (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IF_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IF_IDLE  ? IF_FETCH :
                  state_q == IF_FETCH ? (imem.imem_ack ? IF_HOLD : IF_FETCH) :
                  state_q == IF_HOLD  ? (stall ? IF_HOLD : IF_FETCH) : IF_IDLE;
    end

    always_comb begin
        imem.imem_req  = state_q == IF_FETCH;
        imem.imem_addr = pc_q;
        instr_valid    = state_q == IF_HOLD;
    end

    // Ack only captures data in FETCH; acks seen in IDLE/HOLD are dropped.
    always_comb begin
        take    = state_q == IF_FETCH && imem.imem_ack;
        retire  = state_q == IF_HOLD && !stall;
        instr_d = take ? imem.imem_rdata : instr_q;
        pc_d    = retire ? next_pc : pc_q;
        cnt_d   = retire ? cnt_q + 32'd1 : cnt_q;
        err_d   = err_q | (retire & misalign);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= INSTR_NOP;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pc           = pc_q;
    assign instr        = instr_q;
    assign retire_count = cnt_q;
    assign addr_err     = err_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst, stall, branch_en, jump_en, jump_reg_en;
    logic [31:0] rs_data, pc, instr, retire_count;
    logic        instr_valid, addr_err;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_cnt;

    instr_fetch_if imem ();

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_en    (branch_en),
        .jump_en      (jump_en),
        .jump_reg_en  (jump_reg_en),
        .rs_data      (rs_data),
        .imem         (imem),
        .pc           (pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .retire_count (retire_count),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter in FETCH; leaves in HOLD with w captured.
    task automatic fetch(input logic [31:0] w, input int waits);
        logic [31:0] a;
        a = imem.imem_addr;
        for (int k = 0; k < waits; k++) begin
            check("wait_req", {31'd0, imem.imem_req}, 32'd1);
            check("wait_addr", imem.imem_addr, a);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = w;
        tick();
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_req", {31'd0, imem.imem_req}, 32'd0);
        check("hold_instr", instr, w);
    endtask

    // Enter in HOLD with stall low; retire with given controls.
    task automatic retire(input logic br, input logic j, input logic jr, input logic [31:0] rs,
                          input logic [31:0] exp_pc);
        branch_en = br; jump_en = j; jump_reg_en = jr; rs_data = rs;
        tick();
        branch_en = 0; jump_en = 0; jump_reg_en = 0; rs_data = '0;
        exp_cnt++;
        check("ret_pc", pc, exp_pc);
        check("ret_addr", imem.imem_addr, exp_pc);
        check("ret_cnt", retire_count, exp_cnt);
        check("ret_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst = 1; stall = 0; branch_en = 0; jump_en = 0; jump_reg_en = 0; rs_data = '0;
        imem.imem_ack = 0; imem.imem_rdata = '0;
        exp_cnt = 0;
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem.imem_req}, 32'd0);
        check("rst_cnt", retire_count, 32'd0);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        rst = 0;
        tick();
        // Back-to-back sequential fetches, 2 cycles each.
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", imem.imem_addr, 32'(i * 4));
            check("seq_req", {31'd0, imem.imem_req}, 32'd1);
            fetch(32'hA000_0000 + 32'(i), 0);
            retire(0, 0, 0, '0, 32'(i * 4 + 4));
        end
        check("seq_cnt3", retire_count, 32'd3);
        // j to 0x100
        fetch(32'h0800_0040, 0);
        retire(0, 1, 0, '0, 32'h100);
        // taken backward branch from 0x100 -> 0xFC
        fetch(32'h1000_FFFE, 0);
        retire(1, 0, 0, '0, 32'hFC);
        // jr back to 0x100, then not-taken branch -> 0x104
        fetch(32'h0, 0);
        retire(0, 0, 1, 32'h100, 32'h100);
        fetch(32'h1000_FFFE, 0);
        retire(0, 0, 0, '0, 32'h104);
        check("noerr", {31'd0, addr_err}, 32'd0);
        // jr to 0xF000_0010, then j keeps the upper nibble
        fetch(32'h0, 0);
        retire(0, 0, 1, 32'hF000_0010, 32'hF000_0010);
        fetch(32'h0800_0040, 0);
        retire(0, 1, 0, '0, 32'hF000_0100);
        // misaligned jr with every enable set: jr wins, error becomes sticky
        fetch(32'h0800_0040, 0);
        retire(1, 1, 1, 32'h0000_2003, 32'h2000);
        check("err_set", {31'd0, addr_err}, 32'd1);
        // delayed ack, then stalled HOLD with junk on the bus
        fetch(32'hDEAD_BEEF, 3);
        stall = 1;
        for (int k = 0; k < 5; k++) begin
            imem.imem_ack = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            tick();
            check("stall_pc", pc, 32'h2000);
            check("stall_instr", instr, 32'hDEAD_BEEF);
            check("stall_req", {31'd0, imem.imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_cnt", retire_count, exp_cnt);
        end
        imem.imem_ack = 0;
        imem.imem_rdata = '0;
        stall = 0;
        retire(0, 0, 0, '0, 32'h2004);
        check("err_sticky", {31'd0, addr_err}, 32'd1);
        // reset in FETCH with a simultaneous ack
        check("pre_rst_req", {31'd0, imem.imem_req}, 32'd1);
        rst = 1;
        imem.imem_ack = 1;
        imem.imem_rdata = 32'h1234_5678;
        tick();
        rst = 0;
        imem.imem_ack = 0;
        imem.imem_rdata = '0;
        check("mrst_pc", pc, 32'h0);
        check("mrst_instr", instr, 32'h0);
        check("mrst_valid", {31'd0, instr_valid}, 32'd0);
        check("mrst_cnt", retire_count, 32'd0);
        check("mrst_err", {31'd0, addr_err}, 32'd0);
        check("mrst_req", {31'd0, imem.imem_req}, 32'd0);
        // late ack while in IDLE is ignored
        imem.imem_ack = 1;
        imem.imem_rdata = 32'h5555_AAAA;
        tick();
        imem.imem_ack = 0;
        imem.imem_rdata = '0;
        check("late_instr", instr, 32'h0);
        check("late_req", {31'd0, imem.imem_req}, 32'd1);
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the EE108B MIPS core. Holds the architectural PC, fetches the instruction word through a req/ack handshake with instruction memory, and presents a stable `pc`/`instr` pair to decode. When the instruction retires, it computes the next PC from decode's `branch_en`/`jump_en`/`jump_reg_en`. No branch delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: downstream hold. While high, the held instruction does not retire.
- `branch_en` in 1: current instruction is a taken branch.
- `jump_en` in 1: current instruction is j/jal.
- `jump_reg_en` in 1: current instruction is jr/jalr.
- `rs_data` in 32: jr/jalr target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched word.
- `pc` out 32: address of the held instruction.
- `instr` out 32: held instruction word.
- `instr_valid` out 1: `pc`/`instr` valid for decode.
- `retire_count` out 32: number of retired instructions; wraps at 2^32.
- `addr_err` out 1: sticky. Set when a jr target has nonzero bits [1:0].

## Operation
- FSM states: IDLE, FETCH, HOLD.
  - IDLE → FETCH unconditionally.
  - FETCH → HOLD on `imem_ack`.
  - HOLD → FETCH on `~stall`.
  - HOLD with `stall` high remains in HOLD.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = `pc`, both stable until ack.
  - On the ack edge, `instr` ← `imem_rdata`.
- HOLD:
  - `instr_valid` = 1 and `imem_req` = 0.
  - Retire means HOLD & `~stall`. On retire: `pc` ← next_pc and `retire_count` += 1.
- `imem_ack` outside FETCH is ignored; `instr` is unchanged.
- `branch_en`/`jump_en`/`jump_reg_en`/`rs_data` are sampled only at retire.
- next_pc, with pc4 = `pc` + 4 (mod 2^32), in priority order:
  - `jump_reg_en`: {`rs_data`[31:2], 2'b00}. If `rs_data`[1:0] ≠ 0, set `addr_err`.
  - `jump_en`: {pc4[31:28], `instr`[25:0], 2'b00}.
  - `branch_en`: pc4 + ({{14{`instr`[15]}}, `instr`[15:0], 2'b00}), mod 2^32.
  - otherwise: pc4.
- Multiple enables asserted together: the priority above resolves it; no error is flagged.

## Timing
- Reset values: state = IDLE, `pc` = RESET_PC, `instr` = 0, `instr_valid` = 0, `imem_req` = 0, `retire_count` = 0, `addr_err` = 0.
- First edge with `rst` = 0: IDLE → FETCH. `imem_req` rises in the following cycle.
- Ack in the first FETCH cycle gives the minimum rate: 1 FETCH cycle + 1 HOLD cycle, so 2 cycles per instruction.
- `instr_valid` rises in the cycle after the ack edge and falls in the cycle after the retire edge.
- `pc` and `instr` change only on the retire edge and the ack edge, respectively. Both are stable for the whole HOLD period.
- `rst` mid-operation (any state, including an outstanding request): all state returns to reset values on that edge and `imem_req` drops next cycle. A late ack is ignored because the FSM is in IDLE.
- `rst` has priority over ack and retire on the same edge.
- `retire_count` wraps from 32'hFFFF_FFFF to 0 without a flag.

## Structure
- `mips_defines.v` additions:
  - state encodings `IF_IDLE`/`IF_FETCH`/`IF_HOLD` (2-bit);
  - `INSTR_NOP` = 32'h0.
- One combinational sub-module, `next_pc_calc`:
  - inputs: `pc`, `instr`, the enables, `rs_data`;
  - outputs: next_pc, misalign.
- The top level holds the FSM, the PC/instr registers, the counter and the sticky error.

## Test plan
- Reset, then ack after 0 wait cycles, no enables, `stall` = 0. Required: `imem_addr` sequence 0, 4, 8; `instr_valid` every 2nd cycle; `retire_count` = 3 after 6 cycles.
- `pc` = 0x100, `instr`[15:0] = 0xFFFE, `branch_en` = 1 at retire. Required: next `imem_addr` = 0xFC. Same with `branch_en` = 0: 0x104.
- `pc` = 0xF000_0010, `jump_en`, `instr`[25:0] = 0x0000040. Required: next `pc` = 0xF000_0100.
- `jump_reg_en`, `rs_data` = 0x0000_2003. Required: next `pc` = 0x2000; `addr_err` rises and stays 1 until `rst`.
- `stall` high for 5 HOLD cycles; ack delayed 3 cycles with random junk on `imem_ack` during HOLD. Required: `pc`/`instr` unchanged, `imem_req` = 0 in HOLD, `retire_count` unchanged until `stall` drops.
- `rst` asserted during FETCH with ack arriving the same cycle. Required: next cycle `pc` = RESET_PC, `instr` = 0, `instr_valid` = 0, `retire_count` = 0; the ack data is discarded.
